prbs_rx_checker: RTL and testbench

- Receive-side counterpart of the fabric PRBS-7 transmitter that drives the GTX TX lanes.
- One instance per lane, on the RX user clock, after the GTX RX parallel output.
- Self-synchronises to the incoming PRBS-7 stream, declares lock, and counts word and bit errors (including the deliberate errors produced by the TX inject control).
- Drives lock and error status toward the front-panel LEDs and the VIO.

---
 rtl/prbs_pkg.sv | 35 +++
 rtl/prbs_popcount.sv | 31 +++
 rtl/prbs_rx_checker.sv | 165 ++++++++++++++++
 tb/tb_prbs_rx_checker.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS-7 definitions: taps, seed, checker states and the word-advance function
// used by both the TX generator and the RX checker so their bit order is identical.
package prbs_pkg;

  localparam int         PRBS7_TAP_A = 7;
  localparam int         PRBS7_TAP_B = 6;
  localparam logic [6:0] PRBS7_SEED  = 7'h7F;
  localparam int         PRBS_MAX_W  = 64;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } prbs_state_t;

  // state[0] is the newest bit. The result holds nbits new bits right-aligned,
  // first generated bit at position nbits-1, so result[6:0] is the next state.
  function automatic logic [PRBS_MAX_W-1:0] prbs7_adv(input logic [6:0] state,
                                                      input int         nbits);
    logic [6:0]            s;
    logic                  nb;
    logic [PRBS_MAX_W-1:0] res;
    s   = state;
    res = '0;
    for (int i = 0; i < PRBS_MAX_W; i++) begin
      if (i < nbits) begin
        nb  = s[PRBS7_TAP_A-1] ^ s[PRBS7_TAP_B-1];
        s   = {s[5:0], nb};
        res = {res[PRBS_MAX_W-2:0], nb};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/prbs_popcount.sv
// Combinational population count of a W-bit vector, built as a balanced adder tree
// over the input padded to the next power of two.
module prbs_popcount
  import prbs_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] count
);

  localparam int P = 1 << $clog2(W);

  logic [P-1:0]  padded;
  logic [CW-1:0] node [1:2*P-1];

  // Leaves sit at node[P..2P-1]; node[i] sums its two children, root is node[1].
  always_comb begin
    padded         = '0;
    padded[W-1:0]  = bits;
    for (int i = 0; i < P; i++) begin
      node[P+i] = {{(CW-1){1'b0}}, padded[i]};
    end
    for (int i = P - 1; i >= 1; i--) begin
      node[i] = node[2*i] + node[2*i+1];
    end
    count = node[1];
  end

endmodule

// File: rtl/prbs_rx_checker.sv
// Per-lane PRBS-7 receive checker: self-synchronises, declares lock, counts word/bit errors.
// Optional macro ERR_STRETCH_EN stretches led_err to STRETCH_CYCLES clocks per error.
module prbs_rx_checker
  import prbs_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int LOCK_CNT       = 16,
  parameter int LOSS_CNT       = 4,
  parameter int STRETCH_CYCLES = 4000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              clear_cnt,
  output logic              locked,
  output logic              err_pulse,
  output logic [31:0]       err_word_cnt,
  output logic [31:0]       err_bit_cnt,
  output logic              led_err
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  localparam int PW = $clog2(DATA_W + 1);

  if (DATA_W < 8 || DATA_W > PRBS_MAX_W || STRETCH_CYCLES < 1) begin : g_bad_param
    $error("prbs_rx_checker: DATA_W must be 8..64 and STRETCH_CYCLES >= 1");
  end

  prbs_state_t       state, state_nxt;
  logic [GW-1:0]     good_cnt, good_nxt;
  logic [BW-1:0]     bad_run, bad_nxt;
  logic [6:0]        lfsr, lfsr_nxt;
  logic [6:0]        d0;
  logic [DATA_W-1:0] d1;
  logic [DATA_W-1:0] exp_self, exp_lock, exp_word, mism;
  logic [PW-1:0]     mism_bits;
  logic              err_nxt;
  logic [31:0]       word_cnt, bit_cnt;
  logic [32:0]       word_sum, bit_sum;

  // Only the newest 7 bits of the previous word are needed to predict the next one.
  assign exp_self = DATA_W'(prbs7_adv(d0, DATA_W));
  assign exp_lock = DATA_W'(prbs7_adv(lfsr, DATA_W));

  prbs_popcount #(.W(DATA_W), .CW(PW)) u_popcount (
    .bits  (mism),
    .count (mism_bits)
  );

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    bad_nxt   = bad_run;
    lfsr_nxt  = lfsr;
    err_nxt   = 1'b0;
    exp_word  = (state == LOCKED) ? exp_lock : exp_self;
    mism      = d1 ^ exp_word;
    if (rx_valid) begin
      unique case (state)
        HUNT: begin
          if (mism == '0 && d1[6:0] != 7'd0) begin
            state_nxt = VERIFY;
            good_nxt  = GW'(1);
          end
        end
        VERIFY: begin
          if (mism == '0) begin
            good_nxt = good_cnt + GW'(1);
            if (good_cnt == GW'(LOCK_CNT - 1)) begin
              state_nxt = LOCKED;
              lfsr_nxt  = d1[6:0];
              bad_nxt   = '0;
            end
          end else begin
            state_nxt = HUNT;
            good_nxt  = '0;
          end
        end
        LOCKED: begin
          // Free-running from here on: a corrupted word never reseeds the reference.
          lfsr_nxt = exp_lock[6:0];
          if (mism != '0) begin
            err_nxt = 1'b1;
            if (bad_run == BW'(LOSS_CNT - 1)) begin
              state_nxt = HUNT;
              bad_nxt   = '0;
              good_nxt  = '0;
            end else begin
              bad_nxt = bad_run + BW'(1);
            end
          end else begin
            bad_nxt = '0;
          end
        end
        default: begin
          state_nxt = HUNT;
          good_nxt  = '0;
          bad_nxt   = '0;
        end
      endcase
    end
  end

  assign word_sum = {1'b0, word_cnt} + 33'd1;
  assign bit_sum  = {1'b0, bit_cnt} + 33'(mism_bits);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= HUNT;
      good_cnt  <= '0;
      bad_run   <= '0;
      lfsr      <= PRBS7_SEED;
      d0        <= '0;
      d1        <= '0;
      err_pulse <= 1'b0;
      word_cnt  <= '0;
      bit_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      good_cnt  <= good_nxt;
      bad_run   <= bad_nxt;
      lfsr      <= lfsr_nxt;
      err_pulse <= err_nxt;
      if (rx_valid) begin
        d0 <= d1[6:0];
        d1 <= rx_data;
      end
      if (clear_cnt) begin
        word_cnt <= '0;
        bit_cnt  <= '0;
      end else if (err_nxt) begin
        word_cnt <= word_sum[32] ? 32'hFFFF_FFFF : word_sum[31:0];
        bit_cnt  <= bit_sum[32]  ? 32'hFFFF_FFFF : bit_sum[31:0];
      end
    end
  end

  assign locked       = (state == LOCKED);
  assign err_word_cnt = word_cnt;
  assign err_bit_cnt  = bit_cnt;

`ifdef ERR_STRETCH_EN
  localparam int SW = $clog2(STRETCH_CYCLES + 1);

  logic [SW-1:0] stretch;

  // The pulse cycle itself is the first lit cycle, hence the reload of N-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stretch <= '0;
    end else if (err_pulse) begin
      stretch <= SW'(STRETCH_CYCLES - 1);
    end else if (stretch != '0) begin
      stretch <= stretch - SW'(1);
    end
  end

  assign led_err = err_pulse || (stretch != '0);
`else
  assign led_err = err_pulse;
`endif

endmodule

// File: tb/tb_prbs_rx_checker.sv
// Directed testbench for prbs_rx_checker: lock-up, bit/word error counting, loss and
// relock, saturation, clear priority, async reset, rx_valid gaps and led_err length.
module tb_prbs_rx_checker;

  localparam int DW = 16;

  logic          clk;
  logic          reset_n;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          clear_cnt;
  logic          locked;
  logic          err_pulse;
  logic [31:0]   err_word_cnt;
  logic [31:0]   err_bit_cnt;
  logic          led_err;

  int checks   = 0;
  int failures = 0;

  bit hist[$];

  prbs_rx_checker #(
    .DATA_W         (DW),
    .LOCK_CNT       (16),
    .LOSS_CNT       (4),
    .STRETCH_CYCLES (10)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .clear_cnt    (clear_cnt),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_word_cnt (err_word_cnt),
    .err_bit_cnt  (err_bit_cnt),
    .led_err      (led_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference stream kept as a plain bit history: b[n] = b[n-6] ^ b[n-7], seed all ones.
  task automatic gen_reset();
    hist.delete();
    repeat (7) hist.push_back(1'b1);
  endtask

  task automatic gen_word(output logic [DW-1:0] w);
    bit nb;
    w = '0;
    for (int i = 0; i < DW; i++) begin
      nb = hist[hist.size()-6] ^ hist[hist.size()-7];
      hist.push_back(nb);
      void'(hist.pop_front());
      w[DW-1-i] = nb;
    end
  endtask

  task automatic step(input logic [DW-1:0] d, input logic v);
    rx_data  = d;
    rx_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL reset_locked: got %0b want 0", locked); end
    checks++; if (err_pulse !== 1'b0) begin failures++; $display("[TB] FAIL reset_err_pulse: got %0b want 0", err_pulse); end
    checks++; if (err_word_cnt !== 32'd0) begin failures++; $display("[TB] FAIL reset_word_cnt: got %0h want 0", err_word_cnt); end
    checks++; if (err_bit_cnt !== 32'd0) begin failures++; $display("[TB] FAIL reset_bit_cnt: got %0h want 0", err_bit_cnt); end
    checks++; if (led_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_led_err: got %0b want 0", led_err); end
  endtask

  task automatic test_lock();
    logic [DW-1:0] w;
    gen_reset();
    reset_n = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      gen_word(w);
      step(w, 1'b1);
      checks++; if (err_pulse !== 1'b0) begin failures++; $display("[TB] FAIL lock_err_pulse word %0d: got %0b want 0", k, err_pulse); end
      if (k == 17) begin
        checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL lock_early: got %0b want 0", locked); end
      end
      if (k == 18) begin
        checks++; if (locked !== 1'b1) begin failures++; $display("[TB] FAIL lock_rise: got %0b want 1", locked); end
      end
    end
    checks++; if (err_word_cnt !== 32'd0) begin failures++; $display("[TB] FAIL lock_word_cnt: got %0h want 0", err_word_cnt); end
    checks++; if (err_bit_cnt !== 32'd0) begin failures++; $display("[TB] FAIL lock_bit_cnt: got %0h want 0", err_bit_cnt); end
  endtask

  task automatic test_single_bit();
    logic [DW-1:0] w;
    gen_word(w);
    step(w ^ 16'h0100, 1'b1);
    checks++; if (err_pulse !== 1'b0) begin failures++; $display("[TB] FAIL single_early: got %0b want 0", err_pulse); end
    gen_word(w);
    step(w, 1'b1);
    checks++; if (err_pulse !== 1'b1) begin failures++; $display("[TB] FAIL single_pulse: got %0b want 1", err_pulse); end
    checks++; if (err_word_cnt !== 32'd1) begin failures++; $display("[TB] FAIL single_word_cnt: got %0h want 1", err_word_cnt); end
    checks++; if (err_bit_cnt !== 32'd1) begin failures++; $display("[TB] FAIL single_bit_cnt: got %0h want 1", err_bit_cnt); end
    gen_word(w);
    step(w, 1'b1);
    checks++; if (err_pulse !== 1'b0) begin failures++; $display("[TB] FAIL single_pulse_len: got %0b want 0", err_pulse); end
    checks++; if (locked !== 1'b1) begin failures++; $display("[TB] FAIL single_locked: got %0b want 1", locked); end
    checks++; if (err_word_cnt !== 32'd1) begin failures++; $display("[TB] FAIL single_once: got %0h want 1", err_word_cnt); end
  endtask

  task automatic test_multi_bit();
    logic [DW-1:0] w;
    gen_word(w);
    step(w ^ 16'h8401, 1'b1);
    gen_word(w);
    step(w, 1'b1);
    checks++; if (err_word_cnt !== 32'd2) begin failures++; $display("[TB] FAIL multi_word_cnt: got %0h want 2", err_word_cnt); end
    checks++; if (err_bit_cnt !== 32'd4) begin failures++; $display("[TB] FAIL multi_bit_cnt: got %0h want 4", err_bit_cnt); end
    gen_word(w);
    step(w, 1'b1);
    checks++; if (locked !== 1'b1) begin failures++; $display("[TB] FAIL multi_locked: got %0b want 1", locked); end
  endtask

  task automatic test_loss_relock();
    logic [DW-1:0] w;
    for (int g = 1; g <= 4; g++) begin
      gen_word(w);
      step(w ^ 16'hFFFF, 1'b1);
    end
    checks++; if (locked !== 1'b1) begin failures++; $display("[TB] FAIL loss_early: got %0b want 1", locked); end
    gen_word(w);
    step(w, 1'b1);
    checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL loss_fall: got %0b want 0", locked); end
    checks++; if (err_pulse !== 1'b1) begin failures++; $display("[TB] FAIL loss_pulse: got %0b want 1", err_pulse); end
    checks++; if (err_word_cnt !== 32'd6) begin failures++; $display("[TB] FAIL loss_word_cnt: got %0h want 6", err_word_cnt); end
    checks++; if (err_bit_cnt !== 32'd68) begin failures++; $display("[TB] FAIL loss_bit_cnt: got %0h want 68", err_bit_cnt); end
    for (int j = 1; j <= 17; j++) begin
      gen_word(w);
      step(w, 1'b1);
      if (j == 16) begin
        checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL relock_early: got %0b want 0", locked); end
      end
      if (j == 17) begin
        checks++; if (locked !== 1'b1) begin failures++; $display("[TB] FAIL relock_rise: got %0b want 1", locked); end
      end
    end
    checks++; if (err_word_cnt !== 32'd6) begin failures++; $display("[TB] FAIL relock_word_cnt: got %0h want 6", err_word_cnt); end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] w;
    force dut.word_cnt = 32'hFFFF_FFFE;
    force dut.bit_cnt  = 32'hFFFF_FFFE;
    gen_word(w);
    step(w, 1'b1);
    release dut.word_cnt;
    release dut.bit_cnt;
    gen_word(w);
    step(w ^ 16'h0007, 1'b1);
    gen_word(w);
    step(w ^ 16'h0007, 1'b1);
    checks++; if (err_word_cnt !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL sat_word_first: got %0h want ffffffff", err_word_cnt); end
    checks++; if (err_bit_cnt !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL sat_bit_clamp: got %0h want ffffffff", err_bit_cnt); end
    gen_word(w);
    step(w, 1'b1);
    checks++; if (err_pulse !== 1'b1) begin failures++; $display("[TB] FAIL sat_pulse: got %0b want 1", err_pulse); end
    checks++; if (err_word_cnt !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL sat_word_hold: got %0h want ffffffff", err_word_cnt); end
    checks++; if (err_bit_cnt !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL sat_bit_hold: got %0h want ffffffff", err_bit_cnt); end
    gen_word(w);
    step(w ^ 16'h0001, 1'b1);
    clear_cnt = 1'b1;
    gen_word(w);
    step(w, 1'b1);
    clear_cnt = 1'b0;
    checks++; if (err_pulse !== 1'b1) begin failures++; $display("[TB] FAIL clear_pulse: got %0b want 1", err_pulse); end
    checks++; if (err_word_cnt !== 32'd0) begin failures++; $display("[TB] FAIL clear_word_cnt: got %0h want 0", err_word_cnt); end
    checks++; if (err_bit_cnt !== 32'd0) begin failures++; $display("[TB] FAIL clear_bit_cnt: got %0h want 0", err_bit_cnt); end
    gen_word(w);
    step(w, 1'b1);
    checks++; if (locked !== 1'b1) begin failures++; $display("[TB] FAIL clear_locked: got %0b want 1", locked); end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] w;
    gen_word(w);
    step(w ^ 16'h0001, 1'b1);
    gen_word(w);
    step(w, 1'b1);
    checks++; if (err_word_cnt !== 32'd1) begin failures++; $display("[TB] FAIL areset_pre_cnt: got %0h want 1", err_word_cnt); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL areset_locked: got %0b want 0", locked); end
    checks++; if (err_word_cnt !== 32'd0) begin failures++; $display("[TB] FAIL areset_word_cnt: got %0h want 0", err_word_cnt); end
    checks++; if (err_bit_cnt !== 32'd0) begin failures++; $display("[TB] FAIL areset_bit_cnt: got %0h want 0", err_bit_cnt); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_valid_gap();
    logic [DW-1:0] w;
    gen_reset();
    reset_n = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      gen_word(w);
      step(w, 1'b1);
      step(~w, 1'b0);
      checks++; if (err_pulse !== 1'b0) begin failures++; $display("[TB] FAIL gap_err_pulse word %0d: got %0b want 0", k, err_pulse); end
      if (k == 17) begin
        checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL gap_lock_early: got %0b want 0", locked); end
      end
      if (k == 18) begin
        checks++; if (locked !== 1'b1) begin failures++; $display("[TB] FAIL gap_lock_rise: got %0b want 1", locked); end
      end
    end
    checks++; if (err_word_cnt !== 32'd0) begin failures++; $display("[TB] FAIL gap_word_cnt: got %0h want 0", err_word_cnt); end
  endtask

  task automatic test_led();
    logic [DW-1:0] w;
    int high;
    int led_exp;
`ifdef ERR_STRETCH_EN
    led_exp = 10;
`else
    led_exp = 1;
`endif
    high = 0;
    gen_word(w);
    step(w ^ 16'h0010, 1'b1);
    checks++; if (led_err !== 1'b0) begin failures++; $display("[TB] FAIL led_early: got %0b want 0", led_err); end
    for (int i = 0; i < 15; i++) begin
      gen_word(w);
      step(w, 1'b1);
      if (led_err === 1'b1) high++;
    end
    checks++; if (high != led_exp) begin failures++; $display("[TB] FAIL led_len: got %0d cycles want %0d", high, led_exp); end
    checks++; if (err_word_cnt !== 32'd1) begin failures++; $display("[TB] FAIL led_word_cnt: got %0h want 1", err_word_cnt); end
  endtask

  initial begin
    reset_n   = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = '0;
    clear_cnt = 1'b0;
    #12;
    test_reset();
    test_lock();
    test_single_bit();
    test_multi_bit();
    test_loss_relock();
    test_saturation();
    test_async_reset();
    test_valid_gap();
    test_led();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
